// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - shared constants and FSM encoding for the jt6295 channel sequencer
//
// Purpose: channel count, nibble width, default ROM address width and the
// sequencer FSM state type used by jt6295_chan_seq.
package jt6295_pkg;

  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;
  localparam int NIB_W  = 4;
  localparam int AW_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/jt6295_chan_seq.sv
// rtl/jt6295_chan_seq.sv - four-channel ADPCM play-pointer sequencer with round-robin ROM fetch
//
// Purpose: holds per-channel play pointers loaded on start edges, services one
// channel slot per cen pulse, fetches sample bytes from ROM and emits one
// nibble per serviced slot towards the ADPCM decoder.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cen                         slot strobe
//   start, stop                 per-channel levels; rising edges load / halt
//   start_addr, stop_addr, att  channel load values sampled on a start edge
//   busy                        per-channel playing flags
//   rom_addr, rom_cs            ROM byte request
//   rom_data, rom_ok            ROM byte and its valid qualifier
//   nib, nib_ch, nib_att,
//   nib_first, nib_valid        emitted nibble and its tags
//   overrun                     sticky: cen dropped because a slot was pending
module jt6295_chan_seq
  import jt6295_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [CH_NUM-1:0] start,
  input  logic [CH_NUM-1:0] stop,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW-1:0]     stop_addr,
  input  logic [3:0]        att,
  output logic [CH_NUM-1:0] busy,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic [NIB_W-1:0]  nib,
  output logic [CH_W-1:0]   nib_ch,
  output logic [3:0]        nib_att,
  output logic              nib_first,
  output logic              nib_valid,
  output logic              overrun
);

  seq_state_t state, next_state;

  logic [CH_NUM-1:0] start_l, stop_l, start_rise, stop_rise;
  logic [CH_W-1:0]   slot;      // next slot to service
  logic [CH_W-1:0]   cur;       // slot currently in FETCH/EMIT
  logic              settle;    // first FETCH cycle: rom_addr still settling

  logic [AW-1:0]     ch_addr [CH_NUM];
  logic [AW-1:0]     ch_end  [CH_NUM];
  logic [3:0]        ch_att  [CH_NUM];
  logic [7:0]        ch_buf  [CH_NUM];
  logic [CH_NUM-1:0] ch_lo;
  logic [CH_NUM-1:0] ch_first;

  logic take_slot, go_fetch, accept, emit;

  assign start_rise = start & ~start_l;
  assign stop_rise  = stop  & ~stop_l;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    take_slot  = 1'b0;
    go_fetch   = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cen) begin
          take_slot = 1'b1;
          // A start/stop edge landing on the slot being picked reshapes the
          // channel this cycle, so the slot is skipped rather than serviced
          // from stale pointer state.
          if (busy[slot] && !start_rise[slot] && !stop_rise[slot]) begin
            if (ch_lo[slot]) begin
              next_state = ST_EMIT;
            end else begin
              next_state = ST_FETCH;
              go_fetch   = 1'b1;
            end
          end
        end
      end
      ST_FETCH: begin
        if (start_rise[cur] || stop_rise[cur]) begin
          next_state = ST_IDLE;
        end else if (!settle && rom_ok) begin
          accept     = 1'b1;
          next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        next_state = ST_IDLE;
        emit       = !start_rise[cur];
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_l   <= '0;
      stop_l    <= '0;
      slot      <= '0;
      cur       <= '0;
      settle    <= 1'b0;
      busy      <= '0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      overrun   <= 1'b0;
      nib       <= '0;
      nib_ch    <= '0;
      nib_att   <= '0;
      nib_first <= 1'b0;
      nib_valid <= 1'b0;
      ch_lo     <= '0;
      ch_first  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        ch_addr[i] <= '0;
        ch_end[i]  <= '0;
        ch_att[i]  <= '0;
        ch_buf[i]  <= '0;
      end
    end else begin
      start_l   <= start;
      stop_l    <= stop;
      nib_valid <= 1'b0;
      settle    <= 1'b0;

      if (cen && state != ST_IDLE) overrun <= 1'b1;

      if (take_slot) begin
        cur  <= slot;
        slot <= slot + 2'd1;
      end

      if (go_fetch) begin
        rom_addr <= ch_addr[slot];
        rom_cs   <= 1'b1;
        settle   <= 1'b1;
      end

      if (state == ST_FETCH && next_state != ST_FETCH) rom_cs <= 1'b0;

      if (accept) ch_buf[cur] <= rom_data;

      if (emit) begin
        nib_valid    <= 1'b1;
        nib          <= ch_lo[cur] ? ch_buf[cur][3:0] : ch_buf[cur][7:4];
        nib_ch       <= cur;
        nib_att      <= ch_att[cur];
        nib_first    <= ch_first[cur];
        ch_first[cur] <= 1'b0;
        if (!ch_lo[cur]) begin
          ch_lo[cur] <= 1'b1;
        end else begin
          ch_lo[cur] <= 1'b0;
          if (ch_addr[cur] == ch_end[cur]) busy[cur] <= 1'b0;
          else                             ch_addr[cur] <= ch_addr[cur] + AW'(1);
        end
      end

      // Edge handling comes last so a start edge overrides everything above.
      for (int i = 0; i < CH_NUM; i++) begin
        if (stop_rise[i]) busy[i] <= 1'b0;
        if (start_rise[i]) begin
          ch_addr[i]  <= start_addr;
          ch_end[i]   <= stop_addr;
          ch_att[i]   <= att;
          ch_lo[i]    <= 1'b0;
          ch_first[i] <= 1'b1;
          busy[i]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt6295_chan_seq.sv
// tb/tb_jt6295_chan_seq.sv - self-checking bench for jt6295_chan_seq
module tb_jt6295_chan_seq;

  localparam int AW = 18;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] nib;
    logic [3:0] att;
    logic       first;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst, cen;
  logic [3:0]    start, stop, att, busy;
  logic [AW-1:0] start_addr, stop_addr, rom_addr;
  logic          rom_cs, rom_ok;
  logic [7:0]    rom_data;
  logic [3:0]    nib, nib_att;
  logic [1:0]    nib_ch;
  logic          nib_first, nib_valid, overrun;

  int passed = 0;
  int total  = 0;

  jt6295_chan_seq #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .busy(busy),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .nib(nib), .nib_ch(nib_ch), .nib_att(nib_att), .nib_first(nib_first),
    .nib_valid(nib_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM image and responder
  logic [7:0] rom [logic [AW-1:0]];
  int ok_delay = 0;
  int wait_cnt = 0;

  function automatic logic [7:0] rom_rd(logic [AW-1:0] a);
    return rom.exists(a) ? rom[a] : 8'h00;
  endfunction

  always @(negedge clk) begin
    if (rom_cs) begin
      wait_cnt++;
      rom_ok   = (wait_cnt > ok_delay);
      rom_data = rom_rd(rom_addr);
    end else begin
      wait_cnt = 0;
      rom_ok   = 1'b0;
      rom_data = 8'h00;
    end
  end

  // Output monitor
  ev_t           got_q[$];
  logic [AW-1:0] addr_q[$];
  logic          cs_prev = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (nib_valid) begin
      e.ch = nib_ch; e.nib = nib; e.att = nib_att; e.first = nib_first;
      got_q.push_back(e);
    end
    if (rom_cs && !cs_prev) addr_q.push_back(rom_addr);
    cs_prev = rom_cs;
  end

  // Reference model: each started channel becomes a list of nibbles (high
  // half then low half of every byte from start to stop, wrapping); each
  // slot visit hands out the next nibble of that slot's channel.
  ev_t ch_q[4][$];
  ev_t exp_q[$];

  function automatic void model_start(int ch, logic [AW-1:0] sa, logic [AW-1:0] ea, logic [3:0] a);
    logic [AW-1:0] p = sa;
    logic [7:0]    b;
    ev_t           e;
    ch_q[ch].delete();
    for (int k = 0; k < (1 << AW); k++) begin
      b = rom_rd(p);
      e.ch = ch[1:0]; e.att = a;
      e.nib = b[7:4]; e.first = (k == 0);
      ch_q[ch].push_back(e);
      e.nib = b[3:0]; e.first = 1'b0;
      ch_q[ch].push_back(e);
      if (p == ea) break;
      p = p + 1'b1;
    end
  endfunction

  function automatic void model_slots(int first_slot, int n);
    for (int k = first_slot; k < first_slot + n; k++)
      if (ch_q[k % 4].size() > 0) exp_q.push_back(ch_q[k % 4].pop_front());
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cen = 1'b0; start = '0; stop = '0; ok_delay = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete(); addr_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) ch_q[i].delete();
  endtask

  task automatic pulse_cen(int n, int period);
    repeat (n) begin
      @(negedge clk) cen = 1'b1;
      @(negedge clk) cen = 1'b0;
      repeat (period - 2) @(negedge clk);
    end
  endtask

  task automatic do_start(int ch, logic [AW-1:0] sa, logic [AW-1:0] ea, logic [3:0] a);
    @(negedge clk);
    start_addr = sa; stop_addr = ea; att = a; start[ch] = 1'b1;
    @(negedge clk);
    start[ch] = 1'b0;
    model_start(ch, sa, ea, a);
  endtask

  task automatic fill(logic [AW-1:0] sa, int len);
    logic [AW-1:0] p = sa;
    repeat (len) begin
      rom[p] = 8'($urandom);
      p = p + 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 4'h0)      $display("FAIL reset_busy got %h want 0", busy);         else passed++;
    total++; if (rom_cs !== 1'b0)    $display("FAIL reset_rom_cs got %b want 0", rom_cs);     else passed++;
    total++; if (nib_valid !== 1'b0) $display("FAIL reset_nib_valid got %b want 0", nib_valid); else passed++;
    total++; if (overrun !== 1'b0)   $display("FAIL reset_overrun got %b want 0", overrun);   else passed++;
    total++; if (rom_addr !== '0)    $display("FAIL reset_rom_addr got %h want 0", rom_addr); else passed++;
    total++; if ({nib, nib_ch, nib_att, nib_first} !== 11'h0)
      $display("FAIL reset_nib_tags got %h want 0", {nib, nib_ch, nib_att, nib_first}); else passed++;
  endtask

  task automatic test_basic_play();
    logic [3:0] a = 4'($urandom);
    logic [3:0] want_nib [4];
    want_nib[0] = 4'hA; want_nib[1] = 4'h7; want_nib[2] = 4'h3; want_nib[3] = 4'hC;
    apply_reset();
    rom[18'h00100] = 8'hA7;
    rom[18'h00101] = 8'h3C;
    do_start(1, 18'h00100, 18'h00101, a);
    total++; if (busy !== 4'b0010) $display("FAIL basic_busy_start got %b want 0010", busy); else passed++;
    pulse_cen(16, 8);
    total++; if (got_q.size() !== 4) $display("FAIL basic_count got %0d want 4", got_q.size()); else passed++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== {2'd1, want_nib[i], a, (i == 0)})
        $display("FAIL basic_ev%0d got %h want %h", i, got_q[i], {2'd1, want_nib[i], a, (i == 0)});
      else passed++;
    end
    total++; if (addr_q.size() !== 2) $display("FAIL basic_rom_cs_count got %0d want 2", addr_q.size()); else passed++;
    total++; if (busy[1] !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy[1]); else passed++;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] sa = AW'($urandom);
    logic [AW-1:0] sb = AW'($urandom);
    apply_reset();
    fill(sa, 2); fill(sb, 2);
    do_start(0, sa, sa + 1'b1, 4'($urandom));
    do_start(3, sb, sb + 1'b1, 4'($urandom));
    pulse_cen(16, 8);
    model_slots(0, 16);
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL rr_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_q[i].ch !== ((i % 2 == 0) ? 2'd0 : 2'd3))
        $display("FAIL rr_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (busy !== 4'h0) $display("FAIL rr_busy_end got %h want 0", busy); else passed++;
  endtask

  task automatic test_wrap();
    int ch = $urandom_range(0, 3);
    apply_reset();
    rom[18'h3FFFF] = 8'($urandom);
    rom[18'h00000] = 8'($urandom);
    do_start(ch, 18'h3FFFF, 18'h00000, 4'($urandom));
    pulse_cen(16, 8);
    model_slots(0, 16);
    total++; if (got_q.size() !== 4) $display("FAIL wrap_count got %0d want 4", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL wrap_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (addr_q.size() !== 2 || addr_q[0] !== 18'h3FFFF || addr_q[1] !== 18'h00000)
      $display("FAIL wrap_rom_addr got n=%0d first=%h want n=2 3ffff,00000", addr_q.size(),
               (addr_q.size() > 0) ? addr_q[0] : '0);
    else passed++;
    total++; if (busy !== 4'h0) $display("FAIL wrap_busy_end got %h want 0", busy); else passed++;
  endtask

  task automatic test_stop();
    logic [AW-1:0] sa = AW'($urandom);
    apply_reset();
    fill(sa, 10);
    ok_delay = 1000;
    do_start(2, sa, sa + 18'd9, 4'($urandom));
    pulse_cen(3, 8);
    total++; if (rom_cs !== 1'b1) $display("FAIL stop_in_fetch got rom_cs=%b want 1", rom_cs); else passed++;
    stop[2] = 1'b1;
    @(negedge clk);
    stop[2] = 1'b0;
    total++; if (rom_cs !== 1'b0) $display("FAIL stop_rom_cs got %b want 0", rom_cs); else passed++;
    total++; if (busy[2] !== 1'b0) $display("FAIL stop_busy got %b want 0", busy[2]); else passed++;
    ok_delay = 0;
    pulse_cen(8, 8);
    total++; if (got_q.size() !== 0) $display("FAIL stop_no_nib got %0d want 0", got_q.size()); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL stop_overrun got %b want 0", overrun); else passed++;
  endtask

  task automatic test_restart();
    logic [AW-1:0] sa = AW'($urandom);
    logic [AW-1:0] sb = sa + 18'h00100;
    int  t = 0;
    bit  seen = 0;
    apply_reset();
    fill(sa, 2); fill(sb, 2);
    do_start(0, sa, sa + 1'b1, 4'($urandom));
    @(negedge clk) cen = 1'b1;
    @(negedge clk) cen = 1'b0;
    // rom_cs falls on the edge that enters EMIT; start is driven for that cycle.
    while (t < 50) begin
      if (rom_cs) seen = 1;
      else if (seen) break;
      @(negedge clk);
      t++;
    end
    total++; if (t >= 50) $display("FAIL restart_wait got timeout want rom_cs fall"); else passed++;
    start_addr = sb; stop_addr = sb + 1'b1; att = 4'($urandom); start[0] = 1'b1;
    model_start(0, sb, sb + 1'b1, att);
    @(negedge clk);
    start[0] = 1'b0;
    total++; if (got_q.size() !== 0) $display("FAIL restart_abort got %0d nibs want 0", got_q.size()); else passed++;
    pulse_cen(19, 8);
    model_slots(1, 19);
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL restart_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL restart_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (got_q.size() > 0 && got_q[0].first !== 1'b1) $display("FAIL restart_first got %b want 1", got_q[0].first); else passed++;
  endtask

  task automatic test_overrun_reset();
    logic [AW-1:0] sa = AW'($urandom);
    logic [AW-1:0] sb = AW'($urandom);
    apply_reset();
    fill(sa, 1); fill(sb, 1);
    ok_delay = 5;
    do_start(1, sa, sa, 4'($urandom));
    do_start(2, sb, sb, 4'($urandom));
    pulse_cen(60, 2);
    repeat (20) @(negedge clk);
    // Dropped pulses never advance the slot, so ch1 and ch2 strictly alternate.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ch_q[1].pop_front());
      exp_q.push_back(ch_q[2].pop_front());
    end
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else passed++;
    total++; if (got_q.size() !== 4) $display("FAIL ovr_count got %0d want 4", got_q.size()); else passed++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ovr_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++; if (busy !== 4'h0) $display("FAIL ovr_busy_end got %h want 0", busy); else passed++;
    ok_delay = 1000;
    do_start(3, sa, sa + 18'd4, 4'($urandom));
    pulse_cen(4, 8);
    total++; if (rom_cs !== 1'b1) $display("FAIL rst_pre_fetch got rom_cs=%b want 1", rom_cs); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (rom_cs !== 1'b0) $display("FAIL rst_rom_cs got %b want 0", rom_cs); else passed++;
    total++; if (busy !== 4'h0) $display("FAIL rst_busy got %h want 0", busy); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passed++;
    ok_delay = 0;
  endtask

  task automatic test_random_play();
    for (int it = 0; it < 4; it++) begin
      logic [3:0] mask = 4'($urandom_range(1, 15));
      apply_reset();
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          logic [AW-1:0] sa = AW'($urandom);
          int len = $urandom_range(1, 3);
          fill(sa, len);
          do_start(c, sa, sa + AW'(len - 1), 4'($urandom));
        end
      end
      pulse_cen(28, 8);
      model_slots(0, 28);
      total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_ev%0d got %h want %h", it, i, got_q[i], exp_q[i]);
        else passed++;
      end
      total++; if (busy !== 4'h0) $display("FAIL rand%0d_busy_end got %h want 0", it, busy); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; start = '0; stop = '0; att = '0;
    start_addr = '0; stop_addr = '0; rom_ok = 1'b0; rom_data = 8'h00;
    test_reset();
    test_basic_play();
    test_round_robin();
    test_wrap();
    test_stop();
    test_restart();
    test_overrun_reset();
    test_random_play();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
